// File: rtl/hazard_ctrl_pkg.sv
// Shared CPU constants for the hazard controller: multiply/divide latencies,
// the E-stage md operation encodings and a helper mapping an op to its latency.
package hazard_ctrl_pkg;

  localparam int MD_LAT_MUL = 5;
  localparam int MD_LAT_DIV = 10;

  localparam logic [1:0] MD_OP_MULT  = 2'd0;
  localparam logic [1:0] MD_OP_MULTU = 2'd1;
  localparam logic [1:0] MD_OP_DIV   = 2'd2;
  localparam logic [1:0] MD_OP_DIVU  = 2'd3;

  // Busy-cycle count loaded into the md counter for a given operation.
  function automatic logic [3:0] md_latency(input logic [1:0] op);
    logic [3:0] lat;
    lat = 4'(MD_LAT_MUL);
    case (op)
      MD_OP_MULT, MD_OP_MULTU: lat = 4'(MD_LAT_MUL);
      MD_OP_DIV, MD_OP_DIVU:   lat = 4'(MD_LAT_DIV);
      default:                 lat = 4'(MD_LAT_MUL);
    endcase
    return lat;
  endfunction

endpackage

// File: rtl/hazard_ctrl_md_busy_cnt.sv
// Multiply/divide occupancy counter. A start seen while idle loads the
// operation latency; the count then runs down to zero. Starts arriving while
// the unit is still busy (including the final count-of-1 cycle) are dropped.
module md_busy_cnt
  import hazard_ctrl_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic [1:0] md_op,
  output logic [3:0] md_cnt,
  output logic       md_busy
);

  logic [3:0] cnt;

  // Load on an idle start, otherwise count down while non-zero.
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt <= 4'd0;
    end else if (cnt != 4'd0) begin
      cnt <= cnt - 4'd1;
    end else if (start) begin
      cnt <= md_latency(md_op);
    end
  end

  assign md_cnt  = cnt;
  assign md_busy = (cnt != 4'd0);

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: detects RAW hazards on rs/rt against the E and M
// stages, and structural hazards on the multiply/divide unit, producing a
// zero-latency stall plus a saturating count of stalled cycles.
module hazard_ctrl
  import hazard_ctrl_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic [4:0]  D_A1,
  input  logic [4:0]  D_A2,
  input  logic [1:0]  Tuse_rs_D,
  input  logic [1:0]  Tuse_rt_D,
  input  logic        D_is_md,
  input  logic [4:0]  E_A3,
  input  logic [1:0]  T_new_E,
  input  logic        RegWrite_E,
  input  logic [4:0]  M_A3,
  input  logic [1:0]  T_new_M,
  input  logic        RegWrite_M,
  input  logic        E_start,
  input  logic [1:0]  E_md_op,
  output logic        stall,
  output logic        F_en,
  output logic        D_en,
  output logic        E_clr,
  output logic        md_busy,
  output logic [3:0]  md_cnt,
  output logic [31:0] stall_cnt
);

  logic rs_hazard;
  logic rt_hazard;
  logic md_hazard;
  logic [31:0] stall_cnt_q;

  md_busy_cnt u_md_busy_cnt (
    .clk     (clk),
    .reset   (reset),
    .start   (E_start),
    .md_op   (E_md_op),
    .md_cnt  (md_cnt),
    .md_busy (md_busy)
  );

  // A source stalls when a later stage will write it too late for D's use;
  // register 0 never creates a dependency.
  always_comb begin
    rs_hazard = 1'b0;
    rt_hazard = 1'b0;
    md_hazard = 1'b0;
    if (D_A1 != 5'd0) begin
      rs_hazard = (RegWrite_E && (E_A3 == D_A1) && (T_new_E > Tuse_rs_D)) ||
                  (RegWrite_M && (M_A3 == D_A1) && (T_new_M > Tuse_rs_D));
    end
    if (D_A2 != 5'd0) begin
      rt_hazard = (RegWrite_E && (E_A3 == D_A2) && (T_new_E > Tuse_rt_D)) ||
                  (RegWrite_M && (M_A3 == D_A2) && (T_new_M > Tuse_rt_D));
    end
    md_hazard = D_is_md && (md_busy || E_start);
  end

  assign stall = rs_hazard || rt_hazard || md_hazard;
  assign F_en  = ~stall;
  assign D_en  = ~stall;
  assign E_clr = stall;

  // Count stalled cycles, holding at all-ones rather than wrapping.
  always_ff @(posedge clk) begin
    if (reset) begin
      stall_cnt_q <= 32'd0;
    end else if (stall && (stall_cnt_q != 32'hFFFF_FFFF)) begin
      stall_cnt_q <= stall_cnt_q + 32'd1;
    end
  end

  assign stall_cnt = stall_cnt_q;

endmodule

// File: doc/hazard_ctrl.md
HAZARD_CTRL -- requirements
Module: hazard_ctrl

Interface
REQ-001 The block SHALL use clock clk, rising edge; reset is reset, synchronous, active-high.
REQ-002 The block SHALL have these ports, in this order:
- clk  in  1  system clock
- reset  in  1  synchronous active-high reset
- D_A1  in  5  rs index of the instruction in D
- D_A2  in  5  rt index of the instruction in D
- Tuse_rs_D  in  2  cycles until D needs rs
- Tuse_rt_D  in  2  cycles until D needs rt
- D_is_md  in  1  D holds mult/multu/div/divu/mfhi/mflo/mthi/mtlo
- E_A3  in  5  destination register in E
- T_new_E  in  2  cycles until E result is ready
- RegWrite_E  in  1  E writes the register file
- M_A3  in  5  destination register in M
- T_new_M  in  2  cycles until M result is ready
- RegWrite_M  in  1  M writes the register file
- E_start  in  1  E holds mult/multu/div/divu this cycle
- E_md_op  in  2  operation: 0 mult, 1 multu, 2 div, 3 divu
- stall  out  1  freeze F and D
- F_en  out  1  PC write enable (=~stall)
- D_en  out  1  F/D register enable (=~stall)
- E_clr  out  1  bubble into D/E register (=stall)
- md_busy  out  1  multiply/divide unit occupied
- md_cnt  out  4  remaining busy cycles
- stall_cnt  out  32  total stall cycles since reset

Function
REQ-003 rs hazard: D_A1!=0 and ((RegWrite_E and E_A3==D_A1 and T_new_E>Tuse_rs_D) or (RegWrite_M and M_A3==D_A1 and T_new_M>Tuse_rs_D)); combinational.
REQ-004 rt hazard: same as REQ-003 with D_A2 and Tuse_rt_D.
REQ-005 md hazard: D_is_md and (md_busy or E_start); combinational.
REQ-006 stall = rs hazard OR rt hazard OR md hazard; F_en, D_en, E_clr derive only from stall; there is zero-cycle latency.
REQ-007 Busy counter: when E_start=1 and md_busy=0, md_cnt loads 5 for E_md_op 0/1 and 10 for E_md_op 2/3 at the next edge.
REQ-008 While md_cnt>0, md_cnt decrements by 1 each cycle.
REQ-009 md_busy = (md_cnt!=0); busy spans exactly 5 or 10 cycles after the start cycle.
REQ-010 E_start while md_busy=1 SHALL be ignored, with no reload; a start on the cycle md_cnt transitions 1->0 is ignored too, because busy is still 1.
REQ-011 stall_cnt increments by 1 on every cycle with stall=1.
REQ-012 stall_cnt saturates at 0xFFFFFFFF.
REQ-013 A D/E bubble (E_clr) SHALL NOT affect md_cnt.

Reset
REQ-014 On reset, md_cnt=0, md_busy=0 and stall_cnt=0 at the next edge.
REQ-015 Reset mid-operation aborts the busy count immediately.
REQ-016 During reset, stall still reflects the combinational hazard inputs.

Structure
REQ-017 Constants MD_LAT_MUL=5, MD_LAT_DIV=10 and the E_md_op encodings SHALL reside in the shared CPU package.
REQ-018 The block has one sub-module, md_busy_cnt, holding the counter of REQ-007..010; hazard comparison stays in hazard_ctrl.

Verification
REQ-019 D_A1=8, Tuse_rs_D=0, E_A3=8, RegWrite_E=1, T_new_E=1 -> stall=1, E_clr=1, F_en=0.
REQ-020 D_A1=0 with E_A3=0, RegWrite_E=1, T_new_E=2 -> stall=0.
REQ-021 E_start=1, E_md_op=2 at cycle 0 -> md_cnt 10..1 on cycles 1-10, md_busy=0 at cycle 11; D_is_md=1 stalls cycles 0-10.
REQ-022 E_start with mult at cycle 0, second start at cycle 3 -> md_cnt continues 2,1,0, no reload.
REQ-023 Div started, reset at cycle 4 -> md_cnt=0, md_busy=0 at cycle 5; stall_cnt=0.
REQ-024 Hold a permanent rs hazard for 7 cycles -> stall_cnt=7.
